// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port load/store arbiter that serialises requests onto a single stalling data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; the default build gives port 0 fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [3:0]        r0_sign_mask,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [3:0]        r1_sign_mask,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_write_data,
  output logic              m_memwrite,
  output logic              m_memread,
  output logic [3:0]        m_sign_mask,
  input  logic [DATA_W-1:0] m_read_data,
  input  logic              m_clk_stall
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t state;
  logic   owner;
  logic   cmd_we;
  logic   grant_valid;
  logic   grant_port;

`ifdef DMEM_ARB_RR_EN
  logic   prio;

  always_comb begin
    grant_valid = r0_req | r1_req;
    if (r0_req && r1_req) grant_port = prio;
    else                  grant_port = r1_req;
  end
`else
  always_comb begin
    grant_valid = r0_req | r1_req;
    grant_port  = ~r0_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      cmd_we       <= 1'b0;
      busy         <= 1'b0;
      r0_done      <= 1'b0;
      r1_done      <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
      m_addr       <= '0;
      m_write_data <= '0;
      m_sign_mask  <= '0;
      m_memread    <= 1'b0;
      m_memwrite   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      prio         <= 1'b0;
`endif
    end else begin
      r0_done    <= 1'b0;
      r1_done    <= 1'b0;
      m_memread  <= 1'b0;
      m_memwrite <= 1'b0;
      case (state)
        IDLE: begin
          // An orphan access left running by a reset must drain before any new grant.
          if (!m_clk_stall && grant_valid) begin
            owner <= grant_port;
            busy  <= 1'b1;
            state <= ISSUE;
            if (grant_port) begin
              cmd_we       <= r1_we;
              m_addr       <= r1_addr;
              m_write_data <= r1_wdata;
              m_sign_mask  <= r1_sign_mask;
              m_memwrite   <= r1_we;
              m_memread    <= ~r1_we;
            end else begin
              cmd_we       <= r0_we;
              m_addr       <= r0_addr;
              m_write_data <= r0_wdata;
              m_sign_mask  <= r0_sign_mask;
              m_memwrite   <= r0_we;
              m_memread    <= ~r0_we;
            end
          end
        end
        ISSUE: state <= WAIT_HI;
        WAIT_HI: begin
          if (m_clk_stall) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!m_clk_stall) begin
            if (!cmd_we) begin
              if (owner) r1_rdata <= m_read_data;
              else       r0_rdata <= m_read_data;
            end
            r0_done <= ~owner;
            r1_done <= owner;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef DMEM_ARB_RR_EN
          prio  <= ~owner;
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: stalling memory device plus an abstract ordering/memory reference.
// Follows DMEM_ARB_RR_EN to pick the expected tie-break rule.
module tb_dmem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sm;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r1_req, r0_we, r1_we;
  logic [11:0] r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic [3:0]  r0_sign_mask, r1_sign_mask;
  logic        r0_done, r1_done;
  logic [31:0] r0_rdata, r1_rdata;
  logic        busy;
  logic [11:0] m_addr;
  logic [31:0] m_write_data;
  logic        m_memwrite, m_memread;
  logic [3:0]  m_sign_mask;
  logic [31:0] m_read_data = '0;
  logic        m_clk_stall;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  logic [31:0] ref_mem [0:4095];
  logic [31:0] exp_rdata [2];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_sign_mask(r0_sign_mask), .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_sign_mask(r1_sign_mask), .r1_done(r1_done), .r1_rdata(r1_rdata),
    .busy(busy), .m_addr(m_addr), .m_write_data(m_write_data),
    .m_memwrite(m_memwrite), .m_memread(m_memread), .m_sign_mask(m_sign_mask),
    .m_read_data(m_read_data), .m_clk_stall(m_clk_stall)
  );

  // Memory device: samples a strobe, raises stall for two cycles, drops it in the third.
  logic [31:0] dev_mem [0:4095];
  logic        dev_stall = 1'b0;
  logic [1:0]  stall_left = 2'd0;
  logic        hold_stall = 1'b0;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign m_clk_stall = dev_stall | hold_stall;

  always @(posedge clk) begin
    if (pre_en) dev_mem[pre_addr] <= pre_data;
    if (m_memread || m_memwrite) begin
      dev_stall  <= 1'b1;
      stall_left <= 2'd2;
      if (m_memwrite) dev_mem[m_addr] <= m_write_data;
      else            m_read_data <= dev_mem[m_addr];
    end else if (stall_left != 2'd0) begin
      stall_left <= stall_left - 2'd1;
      if (stall_left == 2'd1) dev_stall <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    ref_mem[a] = d;
    tick();
    pre_en = 1'b0;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = 12'($urandom_range(0, 31) * 4);
    t.wdata = $urandom;
    t.sm    = 4'($urandom_range(0, 15));
    return t;
  endfunction

  task automatic drive_port(input int p, input logic req, input txn_t t);
    if (p == 0) begin
      r0_req = req; r0_we = t.we; r0_addr = t.addr; r0_wdata = t.wdata; r0_sign_mask = t.sm;
    end else begin
      r1_req = req; r1_we = t.we; r1_addr = t.addr; r1_wdata = t.wdata; r1_sign_mask = t.sm;
    end
  endtask

  task automatic do_reset();
    r0_req = 1'b0;
    r1_req = 1'b0;
    hold_stall = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic test_reset();
    txn_t z;
    z.we = 1'b0; z.addr = '0; z.wdata = '0; z.sm = '0;
    rst_n = 1'b0;
    drive_port(0, 1'b0, z);
    drive_port(1, 1'b0, z);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({r0_done, r1_done, busy, m_memread, m_memwrite, m_addr, m_write_data, m_sign_mask,
         r0_rdata, r1_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b addr=%h wd=%h sm=%h rd0=%h rd1=%h, want all 0",
               busy, m_memread, m_memwrite, m_addr, m_write_data, m_sign_mask, r0_rdata, r1_rdata);
    end
    for (int unsigned a = 0; a < 128; a += 4) preload(12'(a), $urandom);
    #1 rst_n = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    tick();
    n_cmp++;
    if ({r0_done, r1_done, busy, m_memread, m_memwrite} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got done0=%b done1=%b busy=%b rd=%b wr=%b, want 0",
               r0_done, r1_done, busy, m_memread, m_memwrite);
    end
  endtask

  task automatic test_load_p0();
    txn_t t;
    logic [4:0] obs, exp;
    preload(12'h010, 32'hDEADBEEF);
    t.we = 1'b0; t.addr = 12'h010; t.wdata = 32'h0; t.sm = 4'b0100;
    drive_port(0, 1'b1, t);
    for (int c = 1; c <= 6; c++) begin
      tick();
      obs = {m_memread, m_memwrite, r0_done, r1_done, busy};
      exp = {c == 1, 1'b0, c == 5, 1'b0, c <= 5};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL load_p0_seq c=%0d: got rd,wr,d0,d1,busy=%b want %b", c, obs, exp);
      end
      if (c == 1) begin
        n_cmp++;
        if ({m_addr, m_sign_mask} !== {12'h010, 4'b0100}) begin
          n_fail++;
          $display("FAIL load_p0_cmd: got addr=%h sm=%b want 010/0100", m_addr, m_sign_mask);
        end
      end
      if (c == 5) begin
        r0_req = 1'b0;
        exp_rdata[0] = 32'hDEADBEEF;
        n_cmp++;
        if (r0_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL load_p0_rdata: got %h want deadbeef", r0_rdata);
        end
      end
    end
  endtask

  task automatic test_store_p1();
    txn_t t;
    logic [4:0] obs, exp;
    t.we = 1'b1; t.addr = 12'h020; t.wdata = 32'h12345678; t.sm = 4'b0010;
    drive_port(1, 1'b1, t);
    for (int c = 1; c <= 6; c++) begin
      tick();
      obs = {m_memread, m_memwrite, r0_done, r1_done, busy};
      exp = {1'b0, c == 1, 1'b0, c == 5, c <= 5};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL store_p1_seq c=%0d: got rd,wr,d0,d1,busy=%b want %b", c, obs, exp);
      end
      if (c == 1) begin
        n_cmp++;
        if ({m_addr, m_write_data} !== {12'h020, 32'h12345678}) begin
          n_fail++;
          $display("FAIL store_p1_cmd: got addr=%h wd=%h want 020/12345678", m_addr, m_write_data);
        end
      end
      if (c == 5) begin
        r1_req = 1'b0;
        ref_mem[12'h020] = 32'h12345678;
        n_cmp++;
        if ({r1_rdata, r0_rdata} !== {exp_rdata[1], exp_rdata[0]}) begin
          n_fail++;
          $display("FAIL store_p1_rdata: got r1=%h r0=%h want r1=%h r0=%h",
                   r1_rdata, r0_rdata, exp_rdata[1], exp_rdata[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    txn_t q0[$], q1[$];
    txn_t t;
    int exp_order[$];
    int rem0, rem1, i0, i1, k, cyc, p;
    bit ptr, w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_txn());
      q1.push_back(rand_txn());
    end
    rem0 = 3; rem1 = 3; ptr = 1'b0;
    while (rem0 + rem1 > 0) begin
      if (rem0 > 0 && rem1 > 0) w = RR ? ptr : 1'b0;
      else                      w = (rem1 > 0);
      exp_order.push_back(int'(w));
      if (w) rem1--; else rem0--;
      ptr = ~w;
    end
    i0 = 0; i1 = 0; k = 0; cyc = 0;
    drive_port(0, 1'b1, q0[0]);
    drive_port(1, 1'b1, q1[0]);
    while (k < 6 && cyc < 80) begin
      tick();
      cyc++;
      if (m_memread || m_memwrite) begin
        t = (exp_order[k] != 0) ? q1[i1] : q0[i0];
        n_cmp++;
        if ({m_memwrite, m_memread, m_addr, m_write_data, m_sign_mask} !==
            {t.we, ~t.we, t.addr, t.wdata, t.sm}) begin
          n_fail++;
          $display("FAIL b2b_cmd k=%0d: got wr=%b addr=%h wd=%h sm=%h want wr=%b addr=%h wd=%h sm=%h",
                   k, m_memwrite, m_addr, m_write_data, m_sign_mask, t.we, t.addr, t.wdata, t.sm);
        end
      end
      if (r0_done || r1_done) begin
        p = exp_order[k];
        t = (p != 0) ? q1[i1] : q0[i0];
        if (t.we) ref_mem[t.addr] = t.wdata;
        else      exp_rdata[p] = ref_mem[t.addr];
        n_cmp++;
        if ({r1_done, r0_done} !== ((p != 0) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL b2b_order k=%0d: got done1,done0=%b%b want port %0d", k, r1_done, r0_done, p);
        end
        n_cmp++;
        if (cyc != 5 + 6 * k) begin
          n_fail++;
          $display("FAIL b2b_spacing k=%0d: got cycle %0d want %0d", k, cyc, 5 + 6 * k);
        end
        n_cmp++;
        if ({r1_rdata, r0_rdata} !== {exp_rdata[1], exp_rdata[0]}) begin
          n_fail++;
          $display("FAIL b2b_rdata k=%0d: got r1=%h r0=%h want r1=%h r0=%h",
                   k, r1_rdata, r0_rdata, exp_rdata[1], exp_rdata[0]);
        end
        if (p != 0) begin
          i1++;
          if (i1 < 3) drive_port(1, 1'b1, q1[i1]); else r1_req = 1'b0;
        end else begin
          i0++;
          if (i0 < 3) drive_port(0, 1'b1, q0[i0]); else r0_req = 1'b0;
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 6) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d completions want 6", k);
    end
    tick();
  endtask

  task automatic test_single_random();
    txn_t t;
    int p;
    logic [1:0] exp_done;
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      p = int'($urandom_range(0, 1));
      t = rand_txn();
      drive_port(p, 1'b1, t);
      for (int c = 1; c <= 5; c++) begin
        tick();
        exp_done = (c == 5) ? ((p != 0) ? 2'b10 : 2'b01) : 2'b00;
        n_cmp++;
        if ({r1_done, r0_done} !== exp_done) begin
          n_fail++;
          $display("FAIL single_done n=%0d c=%0d: got %b%b want %b", n, c, r1_done, r0_done, exp_done);
        end
      end
      if (p != 0) r1_req = 1'b0; else r0_req = 1'b0;
      if (t.we) ref_mem[t.addr] = t.wdata;
      else      exp_rdata[p] = ref_mem[t.addr];
      n_cmp++;
      if ({r1_rdata, r0_rdata} !== {exp_rdata[1], exp_rdata[0]}) begin
        n_fail++;
        $display("FAIL single_rdata n=%0d: got r1=%h r0=%h want r1=%h r0=%h",
                 n, r1_rdata, r0_rdata, exp_rdata[1], exp_rdata[0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    txn_t t, t1;
    int waited;
    bit seen0;
    t.we = 1'b0; t.addr = 12'h040; t.wdata = '0; t.sm = 4'b1000;
    t1.we = 1'b0; t1.addr = 12'h044; t1.wdata = '0; t1.sm = 4'b0001;
    drive_port(0, 1'b1, t);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    r0_req = 1'b0;
    #1;
    n_cmp++;
    if ({r0_done, r1_done, busy, m_memread, m_memwrite, m_addr, m_write_data, m_sign_mask,
         r0_rdata, r1_rdata} !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: got busy=%b addr=%h wd=%h sm=%h rd0=%h rd1=%h want all 0",
               busy, m_addr, m_write_data, m_sign_mask, r0_rdata, r1_rdata);
    end
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    drive_port(1, 1'b1, t1);
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy, m_memread, m_memwrite, r0_done, r1_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_blocked: got busy,rd,wr,d0,d1=%b%b%b%b%b want 00000",
               busy, m_memread, m_memwrite, r0_done, r1_done);
    end
    tick();
    n_cmp++;
    if ({busy, m_memread, m_memwrite} !== 3'b110) begin
      n_fail++;
      $display("FAIL midreset_issue: got busy,rd,wr=%b%b%b want 110", busy, m_memread, m_memwrite);
    end
    waited = 0;
    seen0 = 1'b0;
    while (!r1_done && waited < 10) begin
      tick();
      waited++;
      if (r0_done) seen0 = 1'b1;
    end
    r1_req = 1'b0;
    exp_rdata[1] = ref_mem[12'h044];
    n_cmp++;
    if (waited != 4 || seen0) begin
      n_fail++;
      $display("FAIL midreset_done: got r1_done after %0d cycles, stray r0_done=%b; want 4, 0", waited, seen0);
    end
    n_cmp++;
    if ({r1_rdata, r0_rdata} !== {exp_rdata[1], exp_rdata[0]}) begin
      n_fail++;
      $display("FAIL midreset_rdata: got r1=%h r0=%h want r1=%h r0=%h",
               r1_rdata, r0_rdata, exp_rdata[1], exp_rdata[0]);
    end
    repeat (2) tick();
  endtask

  task automatic test_stall_idle();
    txn_t t;
    t.we = 1'b0; t.addr = 12'h00C; t.wdata = '0; t.sm = 4'b0110;
    hold_stall = 1'b1;
    drive_port(1, 1'b1, t);
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({busy, m_memread, m_memwrite} !== 3'b000) begin
        n_fail++;
        $display("FAIL stall_idle_hold c=%0d: got busy,rd,wr=%b%b%b want 000", c, busy, m_memread, m_memwrite);
      end
    end
    hold_stall = 1'b0;
    tick();
    n_cmp++;
    if ({busy, m_memread, m_memwrite, m_addr} !== {3'b110, 12'h00C}) begin
      n_fail++;
      $display("FAIL stall_idle_grant: got busy,rd,wr=%b%b%b addr=%h want 110 addr=00c",
               busy, m_memread, m_memwrite, m_addr);
    end
    repeat (4) tick();
    r1_req = 1'b0;
    exp_rdata[1] = ref_mem[12'h00C];
    n_cmp++;
    if ({r1_done, r0_done, r1_rdata} !== {2'b10, exp_rdata[1]}) begin
      n_fail++;
      $display("FAIL stall_idle_done: got d1,d0=%b%b r1=%h want 10 r1=%h",
               r1_done, r0_done, r1_rdata, exp_rdata[1]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_p0();
    test_store_p1();
    test_back_to_back();
    test_single_random();
    test_reset_mid();
    test_stall_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
